// File: rtl/bus_timer.sv
// bus_timer: memory-mapped down-counter with preset, auto-reload and masked irq.
// Registers: CTRL (EN/MODE/IM), PRESET (R/W), COUNT (read-only).
module bus_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CNT,
      S_INT
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        pend_q, pend_d;

   logic wr_ctrl, wr_pre;
   logic en, auto_rl, im;

   assign wr_ctrl = sel & we & (addr == 2'd0);
   assign wr_pre  = sel & we & (addr == 2'd1);
   assign en      = ctrl_q[0];
   assign auto_rl = (ctrl_q[2:1] == 2'b01);
   assign im      = ctrl_q[3];

   // State and register file; async active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         ctrl_q   <= 4'd0;
         preset_q <= 32'd0;
         count_q  <= 32'd0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   // Next state: FSM first, then CPU writes override it
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      // auto-reload pending lives for one cycle only
      pend_d   = auto_rl ? 1'b0 : pend_q;
      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_LOAD;
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (count_q == 32'd0) begin
               state_d = S_INT;
            end else if (count_q == 32'd1) begin
               count_d = 32'd0;
               state_d = S_INT;
            end else begin
               count_d = count_q - 32'd1;
            end
         end
         S_INT: begin
            pend_d = 1'b1;
            if (auto_rl) begin
               state_d = S_LOAD;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (wr_ctrl) begin
         ctrl_d = wdata[3:0];
         pend_d = 1'b0;
      end
      if (wr_pre) begin
         preset_d = wdata;
         pend_d   = 1'b0;
         state_d  = S_IDLE;
      end
   end

   // Read mux, purely address-decoded
   always_comb begin
      rdata = 32'd0;
      case (addr)
         2'd0:    rdata = {28'd0, ctrl_q};
         2'd1:    rdata = preset_q;
         2'd2:    rdata = count_q;
         default: rdata = 32'd0;
      endcase
   end

   assign irq = pend_q & im;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed scenario tests for bus_timer.
// Each task drives one scenario and checks inline.
module tb_bus_timer;

   logic        clk;
   logic        reset;
   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   bus_timer dut (
      .clk   (clk),
      .reset (reset),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      sel   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      step();
      sel   = 1'b0;
      we    = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      addr = a;
      #1;
      v = rdata;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b0;
      sel   = 1'b0;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = 32'd0;
      repeat (2) step();
      for (int a = 0; a < 4; a++) begin
         rd(a[1:0], v);
         checks++;
         if (v !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd%0d got %h exp 0", a, v);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq got %b exp 0", irq);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_oneshot();
      logic [31:0] v;
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      step();
      step();
      for (int i = 0; i < 6; i++) begin
         rd(2'd2, v);
         checks++;
         if (v !== 32'(5 - i)) begin
            errors++;
            $display("FAIL os_count%0d got %h exp %h", i, v, 5 - i);
         end
         if (i < 5) step();
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL os_irq_early got %b exp 0", irq);
      end
      step();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL os_irq_rise got %b exp 1", irq);
      end
      repeat (3) step();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL os_irq_hold got %b exp 1", irq);
      end
      rd(2'd0, v);
      checks++;
      if (v !== 32'h8) begin
         errors++;
         $display("FAIL os_ctrl got %h exp 8", v);
      end
      wr(2'd0, 32'h8);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL os_irq_clr got %b exp 0", irq);
      end
   endtask

   task automatic test_autoreload();
      logic [31:0] v;
      logic        exp;
      int          pulses;
      pulses = 0;
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 22; k++) begin
         step();
         exp = (k >= 6) && (((k - 6) % 5) == 0);
         if (irq === 1'b1) pulses++;
         checks++;
         if (irq !== exp) begin
            errors++;
            $display("FAIL ar_irq_k%0d got %b exp %b", k, irq, exp);
         end
         if (k == 7 || k == 12) begin
            rd(2'd2, v);
            checks++;
            if (v !== 32'd3) begin
               errors++;
               $display("FAIL ar_reload_k%0d got %h exp 3", k, v);
            end
         end
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL ar_pulses got %0d exp 4", pulses);
      end
      wr(2'd0, 32'h0);
   endtask

   task automatic test_mask();
      logic [31:0] v;
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      for (int k = 1; k <= 7; k++) begin
         step();
         checks++;
         if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_irq_k%0d got %b exp 0", k, irq);
         end
         if (k == 4) begin
            rd(2'd2, v);
            checks++;
            if (v !== 32'd0) begin
               errors++;
               $display("FAIL mask_count got %h exp 0", v);
            end
         end
      end
      rd(2'd0, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL mask_ctrl got %h exp 0", v);
      end
      wr(2'd0, 32'h8);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL mask_unmask0 got %b exp 0", irq);
      end
      step();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL mask_unmask1 got %b exp 0", irq);
      end
   endtask

   task automatic test_edge();
      logic [31:0] v;
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      repeat (2) step();
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL edge_irq_early got %b exp 0", irq);
      end
      repeat (2) step();
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL edge_irq_rise got %b exp 1", irq);
      end
      rd(2'd2, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL edge_nowrap got %h exp 0", v);
      end
      wr(2'd2, 32'hFFFF);
      rd(2'd2, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL edge_count_ro got %h exp 0", v);
      end
      sel   = 1'b0;
      we    = 1'b1;
      addr  = 2'd1;
      wdata = 32'h77;
      step();
      addr  = 2'd0;
      wdata = 32'h1;
      step();
      we    = 1'b0;
      wr(2'd3, 32'h5);
      rd(2'd1, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL edge_nosel_pre got %h exp 0", v);
      end
      rd(2'd0, v);
      checks++;
      if (v !== 32'h8) begin
         errors++;
         $display("FAIL edge_nosel_ctrl got %h exp 8", v);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL edge_pend_kept got %b exp 1", irq);
      end
      rd(2'd3, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL edge_rsvd got %h exp 0", v);
      end
   endtask

   task automatic test_freeze();
      logic [31:0] v;
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h1);
      repeat (4) step();
      wr(2'd0, 32'h0);
      rd(2'd2, v);
      checks++;
      if (v !== 32'd7) begin
         errors++;
         $display("FAIL frz_at_stop got %h exp 7", v);
      end
      repeat (3) step();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd7) begin
         errors++;
         $display("FAIL frz_hold got %h exp 7", v);
      end
      wr(2'd0, 32'h1);
      repeat (2) step();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd10) begin
         errors++;
         $display("FAIL frz_restart got %h exp a", v);
      end
      wr(2'd0, 32'h0);
   endtask

   task automatic test_collision();
      logic [31:0] v;
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      repeat (4) step();
      wr(2'd0, 32'h9);
      rd(2'd0, v);
      checks++;
      if (v !== 32'h9) begin
         errors++;
         $display("FAIL col_ctrl got %h exp 9", v);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL col_irq got %b exp 0", irq);
      end
      repeat (2) step();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd2) begin
         errors++;
         $display("FAIL col_reload got %h exp 2", v);
      end
      wr(2'd0, 32'h0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      wr(2'd1, 32'h20);
      wr(2'd0, 32'h1);
      repeat (18) step();
      rd(2'd2, v);
      checks++;
      if (v !== 32'h10) begin
         errors++;
         $display("FAIL rst_pre got %h exp 10", v);
      end
      reset = 1'b0;
      for (int a = 0; a < 3; a++) begin
         rd(a[1:0], v);
         checks++;
         if (v !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_rd%0d got %h exp 0", a, v);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_irq got %b exp 0", irq);
      end
      reset = 1'b1;
      repeat (5) step();
      rd(2'd2, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL rst_idle_count got %h exp 0", v);
      end
      rd(2'd0, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("FAIL rst_idle_ctrl got %h exp 0", v);
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_mask();
      test_edge();
      test_freeze();
      test_collision();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
